// File: rtl/nios2_oci_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nios2_oci_pkg
// Brief    : Shared types and jdo field positions for the OCI debug RAM arbiter.
// Revision : 1.0
// ============================================================================
package nios2_oci_pkg;

    localparam int JDO_W        = 38;
    localparam int JDO_RDEN     = 34;
    localparam int JDO_DATA_LSB = 3;
    localparam int JDO_ADDR_LSB = 17;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        J_RD     = 3'd1,
        J_RDWAIT = 3'd2,
        J_WR     = 3'd3,
        C_RD     = 3'd4,
        C_RDWAIT = 3'd5,
        C_WR     = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ACT_LOAD = 2'd0,
        ACT_RD   = 2'd1,
        ACT_WR   = 2'd2
    } act_t;

    function automatic logic is_jtag_state(input state_t s);
        return (s == J_RD) || (s == J_RDWAIT) || (s == J_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/nios2_ocimem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nios2_ocimem_access_arbiter_if
// Brief    : CPU debug-slave bus between the Nios II core and the OCI RAM arbiter.
// Revision : 1.0
// ============================================================================
interface nios2_ocimem_access_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] avs_address;
    logic              avs_read;
    logic              avs_write;
    logic [DATA_W-1:0] avs_writedata;
    logic [DATA_W-1:0] avs_readdata;
    logic              avs_waitrequest;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata, avs_waitrequest
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata, avs_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/nios2_ocimem_jtag_pending.sv
`default_nettype none
// ============================================================================
// Module   : nios2_ocimem_jtag_pending
// Brief    : One-deep capture of JTAG OCI-memory strobes, owns the JTAG address.
// Revision : 1.0
// ============================================================================
module nios2_ocimem_jtag_pending
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    input  wire logic [JDO_W-1:0]  jdo,
    input  wire logic              take_action_ocimem_a,
    input  wire logic              take_action_ocimem_b,
    input  wire logic              take_no_action_ocimem_a,
    input  wire logic              pop,
    output logic                   pend_valid,
    output act_t                   pend_act,
    output logic [ADDR_W-1:0]      pend_addr,
    output logic [DATA_W-1:0]      pend_data,
    output logic                   strobe_req,
    output logic                   jtag_overrun
);
    localparam logic [ADDR_W-1:0] C_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] r_jtag_addr;
    logic              r_valid;
    act_t              r_act;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic              r_overrun;

    logic              w_any;
    logic              w_multi;
    act_t              w_act;
    logic [ADDR_W-1:0] w_addr;
    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_unused_jdo;

    assign w_any   = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign w_multi = (take_action_ocimem_a & take_action_ocimem_b) |
                     (take_action_ocimem_a & take_no_action_ocimem_a) |
                     (take_action_ocimem_b & take_no_action_ocimem_a);
    assign w_data  = jdo[JDO_DATA_LSB +: DATA_W];
    assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_RDEN+1], jdo[JDO_DATA_LSB-1:0]};

    // The address is resolved and advanced at capture, so execution never touches it.
    always_comb begin
        w_act       = ACT_LOAD;
        w_addr      = r_jtag_addr;
        w_next_addr = r_jtag_addr;
        if (take_action_ocimem_b) begin
            w_act       = ACT_WR;
            w_next_addr = r_jtag_addr + C_ADDR_ONE;
        end else if (take_action_ocimem_a) begin
            w_act       = jdo[JDO_RDEN] ? ACT_RD : ACT_LOAD;
            w_addr      = jdo[JDO_ADDR_LSB +: ADDR_W];
            w_next_addr = jdo[JDO_ADDR_LSB +: ADDR_W];
        end else if (take_no_action_ocimem_a) begin
            w_act       = ACT_RD;
            w_next_addr = r_jtag_addr + C_ADDR_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_jtag_addr <= '0;
            r_valid     <= 1'b0;
            r_act       <= ACT_LOAD;
            r_addr      <= '0;
            r_data      <= '0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_any) begin
                r_jtag_addr <= w_next_addr;
                r_valid     <= (w_act != ACT_LOAD);
                r_act       <= w_act;
                r_addr      <= w_addr;
                r_data      <= w_data;
                if (w_multi || r_valid) begin
                    r_overrun <= 1'b1;
                end
            end else if (pop) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pend_valid   = r_valid;
    assign pend_act     = r_act;
    assign pend_addr    = r_addr;
    assign pend_data    = r_data;
    assign strobe_req   = w_any && (w_act != ACT_LOAD);
    assign jtag_overrun = r_overrun;

endmodule
`default_nettype wire

// File: rtl/nios2_ocimem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nios2_ocimem_access_arbiter
// Brief    : Shares the OCI debug RAM between JTAG debug actions and the CPU slave.
// Revision : 1.0
// ============================================================================
module nios2_ocimem_access_arbiter
    import nios2_oci_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic [JDO_W-1:0]     jdo,
    input  wire logic                 take_action_ocimem_a,
    input  wire logic                 take_action_ocimem_b,
    input  wire logic                 take_no_action_ocimem_a,
    nios2_ocimem_access_arbiter_if.slave avs,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic                      ram_wren,
    output logic [DATA_W-1:0]         ram_wdata,
    input  wire logic [DATA_W-1:0]    ram_rdata,
    output logic [DATA_W-1:0]         MonDReg,
    output logic                      monitor_ready,
    output logic                      jtag_overrun
);
    state_t            r_state;
    logic              r_waitreq;
    logic              r_rd_ack;

    logic              w_pend_valid;
    act_t              w_pend_act;
    logic [ADDR_W-1:0] w_pend_addr;
    logic [DATA_W-1:0] w_pend_data;
    logic              w_strobe_req;
    logic              w_pop;

    assign w_pop = (r_state == IDLE) && w_pend_valid;

    nios2_ocimem_jtag_pending #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pending (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .pop                     (w_pop),
        .pend_valid              (w_pend_valid),
        .pend_act                (w_pend_act),
        .pend_addr               (w_pend_addr),
        .pend_data               (w_pend_data),
        .strobe_req              (w_strobe_req),
        .jtag_overrun            (jtag_overrun)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_waitreq <= 1'b1;
            r_rd_ack  <= 1'b0;
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            ram_wdata <= '0;
            MonDReg   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pend_valid) begin
                        ram_addr <= w_pend_addr;
                        if (w_pend_act == ACT_WR) begin
                            ram_wren  <= 1'b1;
                            ram_wdata <= w_pend_data;
                            r_state   <= J_WR;
                        end else begin
                            r_state   <= J_RD;
                        end
                    end else if (w_strobe_req) begin
                        // A JTAG action lands next cycle; hold the CPU off so JTAG wins.
                        r_state <= IDLE;
                    end else if (avs.avs_read) begin
                        ram_addr <= avs.avs_address;
                        r_state  <= C_RD;
                    end else if (avs.avs_write) begin
                        ram_addr  <= avs.avs_address;
                        ram_wdata <= avs.avs_writedata;
                        ram_wren  <= 1'b1;
                        r_waitreq <= 1'b0;
                        r_state   <= C_WR;
                    end
                end
                J_RD: begin
                    r_state <= J_RDWAIT;
                end
                J_RDWAIT: begin
                    MonDReg <= ram_rdata;
                    r_state <= IDLE;
                end
                J_WR: begin
                    ram_wren <= 1'b0;
                    MonDReg  <= ram_wdata;
                    r_state  <= IDLE;
                end
                C_RD: begin
                    r_waitreq <= 1'b0;
                    r_rd_ack  <= 1'b1;
                    r_state   <= C_RDWAIT;
                end
                C_RDWAIT: begin
                    r_waitreq <= 1'b1;
                    r_rd_ack  <= 1'b0;
                    r_state   <= IDLE;
                end
                C_WR: begin
                    ram_wren  <= 1'b0;
                    r_waitreq <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    ram_wren  <= 1'b0;
                    r_waitreq <= 1'b1;
                    r_rd_ack  <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    assign avs.avs_waitrequest = r_waitreq;
    assign avs.avs_readdata    = r_rd_ack ? ram_rdata : '0;
    assign monitor_ready       = !w_pend_valid && !is_jtag_state(r_state);

endmodule
`default_nettype wire

// File: tb/tb_nios2_ocimem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios2_ocimem_access_arbiter
// Brief    : Scoreboard bench for the OCI debug RAM arbiter with a 1-cycle RAM.
// Revision : 1.0
// ============================================================================
module tb_nios2_ocimem_access_arbiter;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        ta_a, ta_b, tna_a;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;

    nios2_ocimem_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(32)) avs ();

    nios2_ocimem_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .avs                     (avs),
        .ram_addr                (ram_addr),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_pat(input int i);
        return 32'hA500_0000 + 32'(i);
    endfunction

    // Debug RAM: registered read, 1-cycle latency
    logic [31:0] mem [256];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_pat(i);
            mem_ready <= 1'b1;
        end else if (ram_wren) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    logic [31:0] exp_mem [256];
    logic [31:0] exp_q [$];
    logic [7:0]  jaddr;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic jtag_cmd(input int kind, input logic [7:0] addr, input logic rden, input logic [31:0] data);
        jdo = '0;
        if (kind == 0) begin
            jdo[24:17] = addr;
            jdo[34]    = rden;
            ta_a       = 1'b1;
        end else if (kind == 1) begin
            jdo[34:3] = data;
            ta_b      = 1'b1;
        end else begin
            tna_a = 1'b1;
        end
        @(posedge clk); #1;
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0; jdo = '0;
    endtask

    task automatic jtag_done_check(input string name);
        int n;
        logic [31:0] e;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!monitor_ready && n < 30);
        n_tests++;
        if (!monitor_ready) begin
            n_fail++;
            $display("FAIL %s_timeout: monitor_ready=%b after %0d cycles, required 1", name, monitor_ready, n);
        end else if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s_scoreboard: no expected entry queued, MonDReg=%h", name, MonDReg);
        end else begin
            e = exp_q.pop_front();
            if (MonDReg !== e) begin
                n_fail++;
                $display("FAIL %s: MonDReg=%h required %h", name, MonDReg, e);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] addr,
                              input logic [31:0] wdata, input int exp_cyc, input string name);
        int cyc;
        logic [31:0] e;
        avs.avs_address = addr; avs.avs_writedata = wdata;
        avs.avs_read = rd; avs.avs_write = wr;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (avs.avs_waitrequest && cyc < 30);
        n_tests++;
        if (avs.avs_waitrequest) begin
            n_fail++;
            $display("FAIL %s_timeout: no ack after %0d cycles", name, cyc);
        end else if (cyc != exp_cyc) begin
            n_fail++;
            $display("FAIL %s_latency: ack after %0d cycles, required %0d", name, cyc, exp_cyc);
        end
        if (rd) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s_scoreboard: no expected entry queued", name);
            end else begin
                e = exp_q.pop_front();
                if (avs.avs_readdata !== e) begin
                    n_fail++;
                    $display("FAIL %s_data: avs_readdata=%h required %h", name, avs.avs_readdata, e);
                end
            end
        end
        @(posedge clk); #1;
        avs.avs_read = 1'b0; avs.avs_write = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests += 6;
        if (avs.avs_waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_waitreq: %b required 1", avs.avs_waitrequest); end
        if (MonDReg !== 32'h0)            begin n_fail++; $display("FAIL rst_mondreg: %h required 0", MonDReg); end
        if (monitor_ready !== 1'b1)       begin n_fail++; $display("FAIL rst_ready: %b required 1", monitor_ready); end
        if (ram_wren !== 1'b0)            begin n_fail++; $display("FAIL rst_wren: %b required 0", ram_wren); end
        if (jtag_overrun !== 1'b0)        begin n_fail++; $display("FAIL rst_overrun: %b required 0", jtag_overrun); end
        if (avs.avs_readdata !== 32'h0)   begin n_fail++; $display("FAIL rst_readdata: %h required 0", avs.avs_readdata); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        jaddr = 8'h00;
        @(posedge clk); #1;
    endtask

    task automatic test_jtag_write();
        jtag_cmd(0, 8'h10, 1'b0, 32'h0);
        jaddr = 8'h10;
        n_tests++;
        if (monitor_ready !== 1'b1) begin n_fail++; $display("FAIL load_only_ready: %b required 1", monitor_ready); end
        jtag_cmd(1, 8'h00, 1'b0, 32'hDEAD_BEEF);
        exp_mem[jaddr] = 32'hDEAD_BEEF; exp_q.push_back(32'hDEAD_BEEF); jaddr = jaddr + 8'd1;
        jtag_done_check("jtag_wr_mondreg");
        n_tests++;
        if (mem[8'h10] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL jtag_wr_ram: RAM[10]=%h required deadbeef", mem[8'h10]); end
    endtask

    task automatic test_jtag_read();
        // Timed read of a fresh location: old value 2 edges later, new value 3 edges later
        jtag_cmd(0, 8'h20, 1'b1, 32'h0);
        jaddr = 8'h20; exp_q.push_back(exp_mem[8'h20]);
        @(posedge clk); @(posedge clk); @(negedge clk);
        n_tests++;
        if (MonDReg !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL jtag_rd_early: MonDReg=%h required deadbeef", MonDReg); end
        jtag_done_check("jtag_rd_latency");
        jtag_cmd(0, 8'h10, 1'b1, 32'h0);
        jaddr = 8'h10; exp_q.push_back(exp_mem[8'h10]);
        jtag_done_check("jtag_rd_a");
        jtag_cmd(0, 8'h11, 1'b0, 32'h0);
        jaddr = 8'h11;
        jtag_cmd(2, 8'h00, 1'b0, 32'h0);
        exp_q.push_back(exp_mem[jaddr]); jaddr = jaddr + 8'd1;
        jtag_done_check("jtag_rd_noact");
        jtag_cmd(1, 8'h00, 1'b0, 32'h0BAD_C0DE);
        exp_mem[jaddr] = 32'h0BAD_C0DE; exp_q.push_back(32'h0BAD_C0DE); jaddr = jaddr + 8'd1;
        jtag_done_check("jtag_wr_after_inc");
        n_tests++;
        if (mem[8'h12] !== 32'h0BAD_C0DE) begin n_fail++; $display("FAIL jtag_inc_addr: RAM[12]=%h required 0badc0de", mem[8'h12]); end
    endtask

    task automatic test_wrap();
        jtag_cmd(0, 8'hFF, 1'b0, 32'h0);
        jaddr = 8'hFF;
        jtag_cmd(1, 8'h00, 1'b0, 32'hCAFE_F00D);
        exp_mem[jaddr] = 32'hCAFE_F00D; exp_q.push_back(32'hCAFE_F00D); jaddr = jaddr + 8'd1;
        jtag_done_check("wrap_wr");
        n_tests++;
        if (mem[8'hFF] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wrap_ram: RAM[ff]=%h required cafef00d", mem[8'hFF]); end
        jtag_cmd(2, 8'h00, 1'b0, 32'h0);
        exp_q.push_back(exp_mem[jaddr]); jaddr = jaddr + 8'd1;
        jtag_done_check("wrap_rd_zero");
    endtask

    task automatic test_cpu();
        cpu_access(1'b0, 1'b1, 8'h40, 32'h1234_5678, 2, "cpu_wr");
        exp_mem[8'h40] = 32'h1234_5678;
        exp_q.push_back(exp_mem[8'h40]);
        cpu_access(1'b1, 1'b0, 8'h40, 32'h0, 3, "cpu_rd_back");
        exp_q.push_back(exp_mem[8'h41]);
        cpu_access(1'b1, 1'b0, 8'h41, 32'h0, 3, "cpu_rd_init");
        exp_q.push_back(exp_mem[8'h42]);
        cpu_access(1'b1, 1'b1, 8'h42, 32'hFFFF_FFFF, 3, "cpu_rdwr_is_rd");
        exp_q.push_back(exp_mem[8'h42]);
        cpu_access(1'b1, 1'b0, 8'h42, 32'h0, 3, "cpu_rdwr_no_write");
    endtask

    task automatic test_priority();
        int cyc;
        logic [31:0] e;
        avs.avs_address = 8'h12; avs.avs_read = 1'b1;
        jdo = '0; jdo[24:17] = 8'hFF; jdo[34] = 1'b1; ta_a = 1'b1;
        exp_q.push_back(exp_mem[8'hFF]);
        exp_q.push_back(exp_mem[8'h12]);
        jaddr = 8'hFF;
        @(posedge clk); #1;
        ta_a = 1'b0; jdo = '0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (avs.avs_waitrequest && cyc < 30);
        n_tests += 3;
        if (avs.avs_waitrequest || !monitor_ready) begin
            n_fail++;
            $display("FAIL prio_order: waitreq=%b monitor_ready=%b at CPU ack, required 0/1", avs.avs_waitrequest, monitor_ready);
        end
        e = exp_q.pop_front();
        if (MonDReg !== e) begin n_fail++; $display("FAIL prio_jtag_data: MonDReg=%h required %h", MonDReg, e); end
        e = exp_q.pop_front();
        if (avs.avs_readdata !== e) begin n_fail++; $display("FAIL prio_cpu_data: readdata=%h required %h", avs.avs_readdata, e); end
        @(posedge clk); #1;
        avs.avs_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        jtag_cmd(0, 8'h60, 1'b0, 32'h0);
        jdo = '0; jdo[34:3] = 32'h1111_1111; ta_b = 1'b1;
        @(posedge clk); #1;
        jdo[34:3] = 32'h2222_2222;
        @(posedge clk); #1;
        ta_b = 1'b0; jdo = '0;
        exp_q.push_back(32'h2222_2222);
        jtag_done_check("b2b_second_exec");
        n_tests++;
        if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: %b required 1", jtag_overrun); end
    endtask

    task automatic test_reset_mid_write();
        avs.avs_address = 8'h50; avs.avs_writedata = 32'h55AA_55AA; avs.avs_write = 1'b1;
        @(posedge clk); #2;
        n_tests += 4;
        if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL mid_in_cwr: ram_wren=%b required 1", ram_wren); end
        reset_n = 1'b0;
        #1;
        if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL mid_wren_cleared: ram_wren=%b required 0", ram_wren); end
        avs.avs_write = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        if (mem[8'h50] !== exp_mem[8'h50]) begin n_fail++; $display("FAIL mid_no_write: RAM[50]=%h required %h", mem[8'h50], exp_mem[8'h50]); end
        if (jtag_overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun_cleared: %b required 0", jtag_overrun); end
        @(posedge clk); #1;
        jaddr = 8'h00;
    endtask

    task automatic test_coincident();
        jtag_cmd(0, 8'h30, 1'b0, 32'h0);
        jaddr = 8'h30;
        jdo = '0; jdo[34:3] = 32'h3C3C_3C3C; ta_a = 1'b1; ta_b = 1'b1; tna_a = 1'b1;
        @(posedge clk); #1;
        ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0; jdo = '0;
        exp_mem[jaddr] = 32'h3C3C_3C3C; exp_q.push_back(32'h3C3C_3C3C); jaddr = jaddr + 8'd1;
        jtag_done_check("coinc_b_wins");
        n_tests += 2;
        if (mem[8'h30] !== 32'h3C3C_3C3C) begin n_fail++; $display("FAIL coinc_b_ram: RAM[30]=%h required 3c3c3c3c", mem[8'h30]); end
        if (jtag_overrun !== 1'b1) begin n_fail++; $display("FAIL coinc_overrun: %b required 1", jtag_overrun); end
        jdo = '0; jdo[24:17] = 8'h41; jdo[34] = 1'b1; ta_a = 1'b1; tna_a = 1'b1;
        @(posedge clk); #1;
        ta_a = 1'b0; tna_a = 1'b0; jdo = '0;
        jaddr = 8'h41; exp_q.push_back(exp_mem[8'h41]);
        jtag_done_check("coinc_a_wins");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) exp_mem[i] = init_pat(i);
        reset_n = 1'b0; jdo = '0; ta_a = 1'b0; ta_b = 1'b0; tna_a = 1'b0;
        avs.avs_address = '0; avs.avs_read = 1'b0; avs.avs_write = 1'b0; avs.avs_writedata = '0;
        test_reset();
        test_jtag_write();
        test_jtag_read();
        test_wrap();
        test_cpu();
        test_priority();
        test_back_to_back();
        test_reset_mid_write();
        test_coincident();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
